// File: rtl/inst_axi_bridge.sv
// ---------------------------------------------------------------------------
// inst_axi_bridge
// Read-only bridge from the IF stage's SRAM-like instruction port to a 32-bit
// AXI read master. Each accepted fetch becomes one single-beat AR transaction.
// R beats are returned in issue order as a one-cycle registered data_ok pulse.
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   inst_sram_*         fetch request side (req/addr_ok, data_ok/rdata)
//   ar*                 AXI read-address channel (master)
//   r*, rready          AXI read-data channel (master)
// ---------------------------------------------------------------------------
module inst_axi_bridge #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  ARID_VAL        = 4'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   logic        arvalid_q, arvalid_d;
   logic [31:0] araddr_q,  araddr_d;
   logic [1:0]  size_q,    size_d;
   logic [1:0]  cnt_q,     cnt_d;
   logic        data_ok_q, data_ok_d;
   logic [31:0] rdata_q,   rdata_d;

   logic ar_slot_free;
   logic accept;
   logic r_fire;

   // Write data, strobes, R id and response are not needed by a fetch path.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};

   // The AR register may be refilled in the same cycle it drains.
   assign ar_slot_free = ~arvalid_q | arready;
   assign accept       = resetn & inst_sram_req & ~inst_sram_wr &
                         ar_slot_free & (cnt_q < MAX_CNT);

   // The fetch stage always absorbs data_ok, so R is never back-pressured.
   assign rready = resetn;

   // A beat with nothing outstanding is a protocol error and is dropped.
   assign r_fire = rvalid & rready & rlast & (cnt_q != 2'd0);

   always_comb begin
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      size_d    = size_q;
      cnt_d     = cnt_q;
      data_ok_d = r_fire;
      rdata_d   = rdata_q;

      if (arvalid_q & arready)
         arvalid_d = 1'b0;
      if (accept) begin
         arvalid_d = 1'b1;
         araddr_d  = inst_sram_addr;
         size_d    = inst_sram_size;
      end

      case ({accept, r_fire})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      if (r_fire)
         rdata_d = rdata;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         arvalid_q <= 1'b0;
         araddr_q  <= 32'd0;
         size_q    <= 2'd2;
         cnt_q     <= 2'd0;
         data_ok_q <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         size_q    <= size_d;
         cnt_q     <= cnt_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign inst_sram_addr_ok = accept;
   assign inst_sram_data_ok = data_ok_q;
   assign inst_sram_rdata   = rdata_q;

   assign arid    = ARID_VAL;
   assign araddr  = araddr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = arvalid_q;

endmodule

// File: tb/tb_inst_axi_bridge.sv
module tb_inst_axi_bridge;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req, wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic        aok, dok;
   logic [31:0] ird;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   inst_axi_bridge #(.MAX_OUTSTANDING(MAXO), .ARID_VAL(4'h0)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
      .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
      .inst_sram_addr_ok(aok), .inst_sram_data_ok(dok), .inst_sram_rdata(ird),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Outstanding reads are a plain count; requests waiting for AR acceptance
   // are a queue; a returned beat appears as data_ok on the following cycle.
   logic [31:0] arq[$];
   int          m_cnt       = 0;
   logic        m_dok       = 1'b0;
   logic [31:0] m_rd        = 32'd0;
   logic [31:0] m_last_addr = 32'd0;
   logic [2:0]  m_last_size = 3'd2;

   always @(negedge clk) begin
      logic exp_aok, fire;
      if (chk_en) begin
         exp_aok = resetn && req && !wr && (arq.size() == 0 || arready) && (m_cnt < MAXO);
         chk("addr_ok", 32'(aok), 32'(exp_aok));
         chk("arvalid", 32'(arvalid), 32'(arq.size() != 0));
         chk("araddr",  araddr, m_last_addr);
         chk("arsize",  32'(arsize), 32'(m_last_size));
         chk("data_ok", 32'(dok), 32'(m_dok));
         chk("rdata",   ird, m_rd);
         chk("rready",  32'(rready), 32'(resetn));
         chk("ar_const", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0},
                         {4'h0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 9'd0});
         if (!resetn) begin
            arq.delete();
            m_cnt = 0; m_dok = 1'b0; m_rd = 32'd0;
            m_last_addr = 32'd0; m_last_size = 3'd2;
         end else begin
            fire  = rvalid && rlast && (m_cnt > 0);
            m_dok = fire;
            if (fire) m_rd = rdata;
            if (arq.size() != 0 && arready) void'(arq.pop_front());
            if (exp_aok) begin
               arq.push_back(addr);
               m_last_addr = addr;
               m_last_size = {1'b0, size};
            end
            m_cnt = m_cnt + int'(exp_aok) - int'(fire);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt(); @(posedge clk); #1; endtask
   task automatic smp(); @(negedge clk); endtask
   task automatic do_reset();
      resetn = 1'b0; req = 1'b0; wr = 1'b0; rvalid = 1'b0; arready = 1'b0; size = 2'd2;
      nxt();
      resetn = 1'b1;
   endtask

   logic [31:0] sq[$];
   int pulses;
   bit acc;

   initial begin
      resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'd0;
      addr = 32'd0; wdata = 32'd0; arready = 1'b0; rid = 4'd0;
      rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
      nxt();
      resetn = 1'b1; chk_en = 1'b1;

      // single fetch: accept, AR, R, data_ok three cycles after accept
      req = 1'b1; addr = 32'h1c000000; arready = 1'b1;
      smp(); chk("sf_aok", 32'(aok), 32'd1);
      chk("sf_reset_dok", 32'(dok), 32'd0);
      chk("sf_reset_rd", ird, 32'd0);
      nxt(); req = 1'b0;
      smp(); chk("sf_arvalid", 32'(arvalid), 32'd1); chk("sf_araddr", araddr, 32'h1c000000);
      nxt(); rvalid = 1'b1; rdata = 32'h02800000;
      smp(); chk("sf_dok_early", 32'(dok), 32'd0);
      nxt(); rvalid = 1'b0;
      smp(); chk("sf_dok", 32'(dok), 32'd1); chk("sf_rdata", ird, 32'h02800000);
      nxt();
      smp(); chk("sf_dok_pulse", 32'(dok), 32'd0); chk("sf_rdata_hold", ird, 32'h02800000);

      // outstanding limit
      do_reset();
      req = 1'b1; addr = 32'h1c000000; arready = 1'b1; pulses = 0;
      for (int i = 0; i < 6; i++) begin
         smp(); acc = aok; if (acc) pulses++;
         nxt(); if (acc) addr = addr + 32'd4;
      end
      chk("lim_pulses", 32'(pulses), 32'd2);
      chk("lim_addr", addr, 32'h1c000008);
      rvalid = 1'b1; rdata = 32'h00000001;
      smp(); chk("lim_aok_rbeat", 32'(aok), 32'd0);
      nxt(); rvalid = 1'b0;
      smp(); chk("lim_aok_after", 32'(aok), 32'd1); chk("lim_dok", 32'(dok), 32'd1);
      nxt();

      // AR backpressure
      do_reset();
      req = 1'b1; addr = 32'h1c000100; arready = 1'b0;
      smp(); chk("bp_aok0", 32'(aok), 32'd1);
      nxt(); addr = 32'h1c000104;
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("bp_arvalid", 32'(arvalid), 32'd1);
         chk("bp_araddr", araddr, 32'h1c000100);
         chk("bp_aok_blocked", 32'(aok), 32'd0);
         nxt();
      end
      arready = 1'b1;
      smp(); chk("bp_aok_drain", 32'(aok), 32'd1);
      nxt(); req = 1'b0; arready = 1'b0;
      smp(); chk("bp_arvalid2", 32'(arvalid), 32'd1); chk("bp_araddr2", araddr, 32'h1c000104);
      nxt();

      // R beat and accept in the same cycle with one outstanding
      do_reset();
      req = 1'b1; addr = 32'h1c000200; arready = 1'b1;
      smp(); chk("sim_aok0", 32'(aok), 32'd1);
      nxt(); req = 1'b0;
      nxt(); rvalid = 1'b1; rdata = 32'h11112222; req = 1'b1; addr = 32'h1c000204;
      smp(); chk("sim_aok1", 32'(aok), 32'd1);
      nxt(); rvalid = 1'b0; addr = 32'h1c000208;
      smp(); chk("sim_dok", 32'(dok), 32'd1); chk("sim_rdata", ird, 32'h11112222);
      chk("sim_aok2", 32'(aok), 32'd1);
      nxt(); addr = 32'h1c00020c;
      smp(); chk("sim_aok_full", 32'(aok), 32'd0);
      nxt(); req = 1'b0;

      // write rejection
      do_reset();
      req = 1'b1; wr = 1'b1; arready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         smp(); chk("wr_aok", 32'(aok), 32'd0); chk("wr_arvalid", 32'(arvalid), 32'd0);
         nxt();
      end
      req = 1'b0; wr = 1'b0;

      // stray R beat with nothing outstanding
      do_reset();
      rvalid = 1'b1; rdata = 32'hdeadbeef;
      nxt(); rvalid = 1'b0;
      smp(); chk("stray_dok", 32'(dok), 32'd0); chk("stray_rdata", ird, 32'd0);
      nxt();

      // reset mid-operation
      do_reset();
      req = 1'b1; addr = 32'h1c000000; arready = 1'b1;
      nxt(); addr = 32'h1c000004;
      nxt(); req = 1'b0; arready = 1'b0;
      smp(); chk("rst_arvalid_pre", 32'(arvalid), 32'd1);
      nxt(); resetn = 1'b0;
      nxt(); resetn = 1'b1; req = 1'b1; addr = 32'h1c000008;
      smp(); chk("rst_arvalid", 32'(arvalid), 32'd0); chk("rst_dok", 32'(dok), 32'd0);
      chk("rst_aok", 32'(aok), 32'd1);
      nxt(); req = 1'b0; arready = 1'b1;
      smp(); chk("rst_araddr", araddr, 32'h1c000008);
      nxt(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hcafe0008;
      nxt(); rvalid = 1'b0;
      smp(); chk("rst_dok2", 32'(dok), 32'd1); chk("rst_rdata2", ird, 32'hcafe0008);
      nxt();

      // randomized traffic against an in-order AXI slave
      do_reset();
      sq.delete();
      for (int c = 0; c < 3000; c++) begin
         smp();
         if (resetn) begin
            if (arvalid && arready) sq.push_back(araddr);
            if (rvalid && rready) void'(sq.pop_front());
         end else begin
            sq.delete();
         end
         nxt();
         resetn  = ($urandom_range(0, 99) != 0);
         req     = ($urandom_range(0, 3) != 0);
         wr      = ($urandom_range(0, 15) == 0);
         addr    = 32'h1c000000 + 32'($urandom_range(0, 255) << 2) +
                   32'(($urandom_range(0, 15) == 0) ? 1 : 0);
         size    = 2'($urandom_range(0, 2));
         wstrb   = 4'($urandom);
         wdata   = $urandom;
         arready = ($urandom_range(0, 2) != 0);
         rvalid  = (sq.size() != 0) && ($urandom_range(0, 1) != 0);
         rdata   = $urandom;
         rid     = 4'($urandom);
         rresp   = 2'($urandom);
      end
      req = 1'b0; rvalid = 1'b0; resetn = 1'b1;
      nxt(); nxt();
      smp();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/inst_axi_bridge.md
Name: inst_axi_bridge

Overview:
- Read-only bridge between the IF stage's SRAM-like instruction port and a 32-bit AXI3/AXI4 read master interface.
- Accepts fetch requests on the req/addr_ok handshake and issues single-beat AR transactions.
- Tracks outstanding reads and returns R data in order as a registered data_ok/rdata pulse.
- Sits directly upstream of the fetch stage, between it and the AXI crossbar/memory.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted requests whose R beat has not yet returned (1..3).
- ARID_VAL, 4'h0: constant value driven on arid.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- inst_sram_req  input  1  fetch request valid
- inst_sram_wr  input  1  write flag; must be 0, writes are never accepted
- inst_sram_size  input  2  transfer size; log2 bytes
- inst_sram_wstrb  input  4  ignored
- inst_sram_addr  input  32  fetch address
- inst_sram_wdata  input  32  ignored
- inst_sram_addr_ok  output  1  request accepted this cycle
- inst_sram_data_ok  output  1  one returned instruction valid this cycle
- inst_sram_rdata  output  32  returned instruction
- arid  output  4  = ARID_VAL
- araddr  output  32  read address
- arlen  output  8  = 0
- arsize  output  3  = {1'b0, latched size}
- arburst  output  2  = 2'b01
- arlock  output  2  = 0
- arcache  output  4  = 0
- arprot  output  3  = 0
- arvalid  output  1  AR valid
- arready  input  1  AR ready
- rid  input  4  ignored; ordering is by issue order
- rdata  input  32  read data
- rresp  input  2  ignored; data returned regardless
- rlast  input  1  expected 1 on every beat
- rvalid  input  1  R valid
- rready  output  1  R ready

Behaviour:

Reset (resetn=0 at posedge):
- arvalid=0, araddr=0, arsize=3'd2, outstanding count cnt=0, data_ok=0, inst_sram_rdata=0, rready=0.
- In-flight transactions are abandoned; the AXI slave is reset in the same cycle.

addr_ok (combinational):
- addr_ok = resetn & inst_sram_req & ~inst_sram_wr & ar_slot_free & (cnt < MAX_OUTSTANDING).
- ar_slot_free = ~arvalid | arready, so back-to-back acceptance is allowed when the AR slot drains in the same cycle.
- addr_ok never depends on rvalid.

AR channel:
- On addr_ok in cycle T: araddr <= inst_sram_addr and arsize <= {0,inst_sram_size}; arvalid=1 from T+1.
- arvalid holds with stable araddr/arsize until arready.
- arvalid falls after the handshake unless a new request is accepted in the same cycle, in which case it stays 1 with the new address.
- Misaligned addresses are passed unmodified; the fetch stage flags ADEF itself.

Outstanding counter:
- cnt counts accepted-but-not-returned reads.
- cnt+1 on addr_ok; cnt-1 on the R handshake (rvalid & rready & rlast).
- Both in the same cycle: cnt unchanged.
- cnt never exceeds MAX_OUTSTANDING and never underflows.
- An R beat arriving with cnt=0 is a protocol error: dropped, no data_ok.

R channel:
- rready = resetn; the fetch stage always absorbs data_ok.
- On handshake in cycle R with cnt>0: data_ok=1 and inst_sram_rdata=rdata in cycle R+1, held for one cycle only.
- inst_sram_rdata holds its last value when data_ok=0.

Flush/cancel:
- Cancellation is handled by the fetch stage. The bridge returns data for every accepted request, in order, even after a fetch-stage flush.

Latency:
- Minimum addr_ok to data_ok is 3 cycles, with arready=1 at T+1 and rvalid at T+2.

Test Plan:
- Single fetch: req addr=0x1c000000 at cycle 0, arready=1, rvalid at cycle 2 with rdata=0x02800000 -> addr_ok at cycle 0; arvalid/araddr=0x1c000000 at cycle 1; data_ok=1, rdata=0x02800000 at cycle 3; cnt returns to 0.
- Outstanding limit: req held high with arready=1 and no R beats -> exactly 2 addr_ok pulses (0x1c000000, 0x1c000004); the third request waits until the first R beat lowers cnt, then is accepted that cycle.
- AR backpressure: arready=0 for 4 cycles after the first accept -> araddr stable, no second addr_ok; arready=1 then triggers the handshake and allows the next accept in the same cycle.
- Simultaneous events: an R beat and addr_ok in the same cycle with cnt=1 -> cnt stays 1; data_ok asserts the next cycle.
- Write rejection: req=1 with wr=1 -> addr_ok=0 indefinitely, arvalid stays 0.
- Reset mid-operation: resetn=0 while arvalid=1 and cnt=2 -> the next cycle has arvalid=0, cnt=0, data_ok=0; a following fetch to 0x1c000008 completes normally.
